// File: rtl/weight_pingpong_buff.sv
// rtl/weight_pingpong_buff.sv - double-buffered kernel weight store: streamed shadow load, bank swap, replayable read stream
// Build option: define WB_AUTO_SWAP_EN to swap as soon as the shadow kernel is complete and the reader is idle.
module weight_pingpong_buff #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [7:0]            cfg_kernel_size,
    output logic                  cfg_err,
    input  logic                  wr_valid,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ready,
    output logic                  shadow_full,
    input  logic                  swap_req,
    output logic                  active_valid,
    input  logic                  rd_start,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_last,
    output logic                  rd_busy
);
    localparam int         CW       = $clog2(DEPTH + 1);
    localparam int         AW       = $clog2(DEPTH);
    localparam logic [8:0] MAX_SIZE = 9'(DEPTH);

    typedef enum logic [1:0] {W_IDLE, W_LOAD, W_FULL} w_state_t;
    typedef enum logic {R_IDLE, R_STREAM} r_state_t;

    w_state_t w_state, w_state_next;
    r_state_t r_state, r_state_next;

    logic [DATA_WIDTH-1:0] mem [2][DEPTH];
    logic                  active_bank;
    logic [CW-1:0]         ksize_w;
    logic [CW-1:0]         ksize_r;
    logic [CW-1:0]         wr_cnt;
    logic [CW-1:0]         rd_cnt;
    logic [AW-1:0]         wr_idx;
    logic                  wr_fire;
    logic                  swap;
    logic                  rd_accept;
    logic                  rd_replay;
    logic                  rd_advance;

    assign cfg_err     = (cfg_kernel_size == 8'd0) || ({1'b0, cfg_kernel_size} > MAX_SIZE);
    assign wr_ready    = ((w_state == W_IDLE) && !cfg_err) || (w_state == W_LOAD);
    assign wr_fire     = wr_valid && wr_ready;
    assign shadow_full = (w_state == W_FULL);
    assign rd_busy     = (r_state == R_STREAM);
    assign wr_idx      = (w_state == W_IDLE) ? '0 : wr_cnt[AW-1:0];

`ifdef WB_AUTO_SWAP_EN
    logic unused_swap_req;
    assign unused_swap_req = swap_req;
    assign swap = shadow_full && (r_state == R_IDLE);
`else
    assign swap = shadow_full && (r_state == R_IDLE) && swap_req;
`endif

    // A swap in the same cycle as rd_start counts as a live kernel; the bank flips on the same edge.
    assign rd_accept  = (r_state == R_IDLE) && rd_start && (active_valid || swap);
    assign rd_replay  = rd_busy && rd_last && rd_start;
    assign rd_advance = rd_busy && !rd_last;

    always_comb begin
        w_state_next = w_state;
        case (w_state)
            W_IDLE:  if (wr_fire) w_state_next = (cfg_kernel_size == 8'd1) ? W_FULL : W_LOAD;
            W_LOAD:  if (wr_fire && (wr_cnt == ksize_w - CW'(1))) w_state_next = W_FULL;
            W_FULL:  if (swap) w_state_next = W_IDLE;
            default: w_state_next = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_next = r_state;
        case (r_state)
            R_IDLE:   if (rd_accept) r_state_next = R_STREAM;
            R_STREAM: if (rd_last && !rd_start) r_state_next = R_IDLE;
            default:  r_state_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_state_next;
            r_state <= r_state_next;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ksize_w <= '0;
            wr_cnt  <= '0;
        end else if (wr_fire) begin
            if (w_state == W_IDLE) begin
                ksize_w <= CW'(cfg_kernel_size);
                wr_cnt  <= CW'(1);
            end else begin
                wr_cnt  <= wr_cnt + CW'(1);
            end
        end
    end

    // Weight storage has no reset; only the shadow bank is ever written.
    always_ff @(posedge clk) begin
        if (wr_fire) mem[~active_bank][wr_idx] <= wr_data;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            active_bank  <= 1'b0;
            active_valid <= 1'b0;
            ksize_r      <= '0;
        end else if (swap) begin
            active_bank  <= ~active_bank;
            active_valid <= 1'b1;
            ksize_r      <= ksize_w;
        end
    end

    // Output register: rd_cnt is the index of the next word to present.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_cnt   <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_last  <= 1'b0;
        end else if (rd_replay) begin
            rd_cnt   <= CW'(1);
            rd_valid <= 1'b1;
            rd_data  <= mem[active_bank][0];
            rd_last  <= (ksize_r == CW'(1));
        end else if (rd_advance) begin
            rd_cnt   <= rd_cnt + CW'(1);
            rd_valid <= 1'b1;
            rd_data  <= mem[active_bank][rd_cnt[AW-1:0]];
            rd_last  <= (rd_cnt == ksize_r - CW'(1));
        end else begin
            rd_cnt   <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_last  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_weight_pingpong_buff.sv
// tb/tb_weight_pingpong_buff.sv - randomized self-checking bench for weight_pingpong_buff against a queue-based kernel model
module tb_weight_pingpong_buff;
    localparam int DW    = 16;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [7:0]    cfg_kernel_size = 8'd4;
    logic          cfg_err;
    logic          wr_valid = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_ready;
    logic          shadow_full;
    logic          swap_req = 1'b0;
    logic          active_valid;
    logic          rd_start = 1'b0;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          rd_last;
    logic          rd_busy;

    int checks = 0;
    int passed = 0;

    // Model: the kernel visible to the reader and the kernel sitting in the shadow bank.
    logic [DW-1:0] active_m[$];
    logic [DW-1:0] shadow_m[$];
    logic [DW-1:0] cap_d[$];
    logic          cap_v[$];
    logic          cap_l[$];

    weight_pingpong_buff #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rstn(rstn), .cfg_kernel_size(cfg_kernel_size), .cfg_err(cfg_err),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready), .shadow_full(shadow_full),
        .swap_req(swap_req), .active_valid(active_valid), .rd_start(rd_start),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last), .rd_busy(rd_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached, got no summary want summary");
        $fatal(1, "watchdog");
    end

    task automatic load_kernel(input int k);
        int guard;
        shadow_m = {};
        cfg_kernel_size = 8'(k);
        for (int i = 0; i < k; i++) begin
            guard = 0;
            while (!wr_ready && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            if (guard == 50) begin
                checks++;
                $display("FAIL load_ready: wr_ready=%0b want 1 within 50 cycles", wr_ready);
            end
            wr_valid = 1'b1;
            wr_data  = DW'($urandom);
            shadow_m.push_back(wr_data);
            @(negedge clk);
            if (i == 0) cfg_kernel_size = 8'($urandom);  // must be ignored mid-load
        end
        wr_valid = 1'b0;
        cfg_kernel_size = 8'(k);
    endtask

    task automatic pulse_swap();
        swap_req = 1'b1;
        @(negedge clk);
        swap_req = 1'b0;
    endtask

    task automatic start_stream();
        rd_start = 1'b1;
        @(negedge clk);
        rd_start = 1'b0;
    endtask

    task automatic capture(input int n);
        cap_d = {}; cap_v = {}; cap_l = {};
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cap_d.push_back(rd_data);
            cap_v.push_back(rd_valid);
            cap_l.push_back(rd_last);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if ({rd_valid, rd_last, rd_busy, shadow_full, active_valid} !== 5'b0)
            $display("FAIL reset_flags: got %b want 00000", {rd_valid, rd_last, rd_busy, shadow_full, active_valid}); else passed++;
        checks++; if (rd_data !== '0) $display("FAIL reset_rd_data: got %h want 0", rd_data); else passed++;
        checks++; if (wr_ready !== 1'b1 || cfg_err !== 1'b0)
            $display("FAIL reset_wr_ready: got ready=%0b err=%0b want 1 0", wr_ready, cfg_err); else passed++;
        rstn = 1'b1;
        start_stream();
        checks++; if (rd_busy !== 1'b0) $display("FAIL start_no_kernel: rd_busy=%0b want 0", rd_busy); else passed++;
        pulse_swap();
        @(negedge clk);
        checks++; if (active_valid !== 1'b0 || rd_valid !== 1'b0)
            $display("FAIL swap_no_kernel: active_valid=%0b rd_valid=%0b want 0 0", active_valid, rd_valid); else passed++;
        active_m = {}; shadow_m = {};
    endtask

`ifndef WB_AUTO_SWAP_EN
    task automatic test_basic_load_swap_stream();
        logic [DW-1:0] ed;
        load_kernel(9);
        checks++; if (shadow_full !== 1'b1 || wr_ready !== 1'b0 || active_valid !== 1'b0)
            $display("FAIL basic_full: full=%0b ready=%0b av=%0b want 1 0 0", shadow_full, wr_ready, active_valid); else passed++;
        pulse_swap();
        active_m = shadow_m;
        checks++; if (active_valid !== 1'b1 || shadow_full !== 1'b0)
            $display("FAIL basic_swap: av=%0b full=%0b want 1 0", active_valid, shadow_full); else passed++;
        start_stream();
        checks++; if (rd_busy !== 1'b1 || rd_valid !== 1'b0)
            $display("FAIL basic_latency: busy=%0b valid=%0b want 1 0", rd_busy, rd_valid); else passed++;
        capture(11);
        for (int i = 0; i < 11; i++) begin
            if (i < 9) ed = active_m[i]; else ed = '0;
            checks++;
            if (cap_v[i] !== (i < 9) || cap_d[i] !== ed || cap_l[i] !== (i == 8))
                $display("FAIL basic_word%0d: got v=%0b d=%h l=%0b want v=%0b d=%h l=%0b",
                         i, cap_v[i], cap_d[i], cap_l[i], (i < 9), ed, (i == 8));
            else passed++;
        end
        checks++; if (rd_busy !== 1'b0) $display("FAIL basic_idle: rd_busy=%0b want 0", rd_busy); else passed++;
    endtask

    task automatic test_swap_dropped_midstream();
        logic [DW-1:0] ed;
        load_kernel(9);
        pulse_swap();
        active_m = shadow_m;
        start_stream();
        fork
            capture(10);
            load_kernel(4);
            begin
                repeat (6) @(negedge clk);
                swap_req = 1'b1;
                @(negedge clk);
                swap_req = 1'b0;
            end
        join
        for (int i = 0; i < 10; i++) begin
            if (i < 9) ed = active_m[i]; else ed = '0;
            checks++;
            if (cap_v[i] !== (i < 9) || cap_d[i] !== ed || cap_l[i] !== (i == 8))
                $display("FAIL drop_word%0d: got v=%0b d=%h l=%0b want v=%0b d=%h l=%0b",
                         i, cap_v[i], cap_d[i], cap_l[i], (i < 9), ed, (i == 8));
            else passed++;
        end
        checks++; if (shadow_full !== 1'b1 || rd_busy !== 1'b0)
            $display("FAIL drop_pending: full=%0b busy=%0b want 1 0", shadow_full, rd_busy); else passed++;
        pulse_swap();
        active_m = shadow_m;
        checks++; if (shadow_full !== 1'b0) $display("FAIL drop_late_swap: full=%0b want 0", shadow_full); else passed++;
        start_stream();
        capture(5);
        for (int i = 0; i < 5; i++) begin
            if (i < 4) ed = active_m[i]; else ed = '0;
            checks++;
            if (cap_v[i] !== (i < 4) || cap_d[i] !== ed || cap_l[i] !== (i == 3))
                $display("FAIL drop_b_word%0d: got v=%0b d=%h l=%0b want v=%0b d=%h l=%0b",
                         i, cap_v[i], cap_d[i], cap_l[i], (i < 4), ed, (i == 3));
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] ed;
        load_kernel(3);
        pulse_swap();
        active_m = shadow_m;
        start_stream();
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (i < 6) ed = active_m[i % 3]; else ed = '0;
            checks++;
            if (rd_valid !== (i < 6) || rd_data !== ed || rd_last !== (i == 2 || i == 5))
                $display("FAIL b2b_word%0d: got v=%0b d=%h l=%0b want v=%0b d=%h l=%0b",
                         i, rd_valid, rd_data, rd_last, (i < 6), ed, (i == 2 || i == 5));
            else passed++;
            rd_start = (i == 0 || i == 2);  // i==0 is mid-stream and must be ignored
        end
        rd_start = 1'b0;
        checks++; if (rd_busy !== 1'b0) $display("FAIL b2b_idle: rd_busy=%0b want 0", rd_busy); else passed++;
    endtask

    task automatic test_cfg_err();
        logic [DW-1:0] ed;
        cfg_kernel_size = 8'd0;
        wr_valid = 1'b1;
        wr_data  = DW'($urandom);
        #1;
        checks++; if (cfg_err !== 1'b1 || wr_ready !== 1'b0)
            $display("FAIL cfg_zero: err=%0b ready=%0b want 1 0", cfg_err, wr_ready); else passed++;
        @(negedge clk); @(negedge clk);
        checks++; if (shadow_full !== 1'b0 || wr_ready !== 1'b0)
            $display("FAIL cfg_zero_hold: full=%0b ready=%0b want 0 0", shadow_full, wr_ready); else passed++;
        cfg_kernel_size = 8'(DEPTH + 1);
        #1;
        checks++; if (cfg_err !== 1'b1 || wr_ready !== 1'b0)
            $display("FAIL cfg_over: err=%0b ready=%0b want 1 0", cfg_err, wr_ready); else passed++;
        @(negedge clk);
        wr_valid = 1'b0;
        cfg_kernel_size = 8'(DEPTH);
        #1;
        checks++; if (cfg_err !== 1'b0 || wr_ready !== 1'b1 || shadow_full !== 1'b0)
            $display("FAIL cfg_max_ok: err=%0b ready=%0b full=%0b want 0 1 0", cfg_err, wr_ready, shadow_full); else passed++;
        @(negedge clk);
        load_kernel(1);
        checks++; if (shadow_full !== 1'b1 || wr_ready !== 1'b0)
            $display("FAIL cfg_one_full: full=%0b ready=%0b want 1 0", shadow_full, wr_ready); else passed++;
        pulse_swap();
        active_m = shadow_m;
        start_stream();
        capture(2);
        for (int i = 0; i < 2; i++) begin
            if (i < 1) ed = active_m[0]; else ed = '0;
            checks++;
            if (cap_v[i] !== (i < 1) || cap_d[i] !== ed || cap_l[i] !== (i == 0))
                $display("FAIL one_word%0d: got v=%0b d=%h l=%0b want v=%0b d=%h l=%0b",
                         i, cap_v[i], cap_d[i], cap_l[i], (i < 1), ed, (i == 0));
            else passed++;
        end
    endtask

    task automatic test_random_kernels();
        int k;
        logic [DW-1:0] ed;
        for (int it = 0; it < 6; it++) begin
            k = (it == 0) ? DEPTH : int'($urandom_range(1, DEPTH));
            load_kernel(k);
            pulse_swap();
            active_m = shadow_m;
            start_stream();
            capture(k + 1);
            for (int i = 0; i <= k; i++) begin
                if (i < k) ed = active_m[i]; else ed = '0;
                checks++;
                if (cap_v[i] !== (i < k) || cap_d[i] !== ed || cap_l[i] !== (i == k - 1))
                    $display("FAIL rand_k%0d_word%0d: got v=%0b d=%h l=%0b want v=%0b d=%h l=%0b",
                             k, i, cap_v[i], cap_d[i], cap_l[i], (i < k), ed, (i == k - 1));
                else passed++;
            end
        end
    endtask

    task automatic test_reset_midload();
        logic [DW-1:0] ed;
        load_kernel(9);
        pulse_swap();
        active_m = shadow_m;
        start_stream();
        cfg_kernel_size = 8'd9;
        for (int i = 0; i < 5; i++) begin
            wr_valid = 1'b1;
            wr_data  = DW'($urandom);
            @(negedge clk);
        end
        wr_valid = 1'b0;
        #2 rstn = 1'b0;
        #1;
        checks++; if ({rd_valid, rd_last, rd_busy, shadow_full, active_valid} !== 5'b0 || rd_data !== '0)
            $display("FAIL midreset_outputs: flags=%b data=%h want 00000 0",
                     {rd_valid, rd_last, rd_busy, shadow_full, active_valid}, rd_data); else passed++;
        checks++; if (wr_ready !== 1'b1) $display("FAIL midreset_wr_ready: got %0b want 1", wr_ready); else passed++;
        @(negedge clk);
        rstn = 1'b1;
        active_m = {}; shadow_m = {};
        start_stream();
        checks++; if (rd_busy !== 1'b0 || active_valid !== 1'b0)
            $display("FAIL midreset_idle: busy=%0b av=%0b want 0 0", rd_busy, active_valid); else passed++;
        load_kernel(9);
        checks++; if (shadow_full !== 1'b1) $display("FAIL midreset_reload: full=%0b want 1", shadow_full); else passed++;
        pulse_swap();
        active_m = shadow_m;
        start_stream();
        capture(10);
        for (int i = 0; i < 10; i++) begin
            if (i < 9) ed = active_m[i]; else ed = '0;
            checks++;
            if (cap_v[i] !== (i < 9) || cap_d[i] !== ed || cap_l[i] !== (i == 8))
                $display("FAIL midreset_word%0d: got v=%0b d=%h l=%0b want v=%0b d=%h l=%0b",
                         i, cap_v[i], cap_d[i], cap_l[i], (i < 9), ed, (i == 8));
            else passed++;
        end
    endtask
`else
    task automatic test_auto_swap();
        logic [DW-1:0] ed;
        load_kernel(4);
        checks++; if (shadow_full !== 1'b1) $display("FAIL auto_full: full=%0b want 1", shadow_full); else passed++;
        @(negedge clk);
        active_m = shadow_m;
        checks++; if (active_valid !== 1'b1 || shadow_full !== 1'b0)
            $display("FAIL auto_swap: av=%0b full=%0b want 1 0", active_valid, shadow_full); else passed++;
        start_stream();
        capture(5);
        for (int i = 0; i < 5; i++) begin
            if (i < 4) ed = active_m[i]; else ed = '0;
            checks++;
            if (cap_v[i] !== (i < 4) || cap_d[i] !== ed || cap_l[i] !== (i == 3))
                $display("FAIL auto_a_word%0d: got v=%0b d=%h l=%0b want v=%0b d=%h l=%0b",
                         i, cap_v[i], cap_d[i], cap_l[i], (i < 4), ed, (i == 3));
            else passed++;
        end
        load_kernel(4);
        start_stream();
        active_m = shadow_m;
        checks++; if (shadow_full !== 1'b0 || rd_busy !== 1'b1)
            $display("FAIL auto_start_same_cycle: full=%0b busy=%0b want 0 1", shadow_full, rd_busy); else passed++;
        capture(5);
        for (int i = 0; i < 5; i++) begin
            if (i < 4) ed = active_m[i]; else ed = '0;
            checks++;
            if (cap_v[i] !== (i < 4) || cap_d[i] !== ed || cap_l[i] !== (i == 3))
                $display("FAIL auto_b_word%0d: got v=%0b d=%h l=%0b want v=%0b d=%h l=%0b",
                         i, cap_v[i], cap_d[i], cap_l[i], (i < 4), ed, (i == 3));
            else passed++;
        end
    endtask
`endif

    initial begin
        @(negedge clk);
        test_reset();
`ifdef WB_AUTO_SWAP_EN
        test_auto_swap();
`else
        test_basic_load_swap_stream();
        test_swap_dropped_midstream();
        test_back_to_back();
        test_cfg_err();
        test_random_kernels();
        test_reset_midload();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
